// File: rtl/costas_ftw_ctrl.sv
// Costas loop NCO frequency-word controller.
// Clamps the loop correction, slew-limits the FTW and tracks carrier lock.
module costas_ftw_ctrl #(
  parameter int                FTW_W      = 32,
  parameter int                CORR_W     = 32,
  parameter logic [CORR_W-1:0] MAX_OFFSET = 32'h0100_0000,
  parameter logic [FTW_W-1:0]  SLEW_STEP  = '0,
  parameter logic [CORR_W-1:0] LOCK_TOL   = 32'h0000_1000,
  parameter int                LOCK_CNT   = 64,
  parameter int                UNLOCK_CNT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              iw_Loop_Filter_ReWork_h,
  input  logic              i_hold,
  input  logic [FTW_W-1:0]  i_ftw_ini,
  input  logic [CORR_W-1:0] i_Carrier_Loop_data,
  input  logic              i_Carrier_Loop_valid,
  output logic [FTW_W-1:0]  o_ftw,
  output logic              o_ftw_valid,
  output logic              o_locked,
  output logic              o_sat
);

  localparam int CMAX = (LOCK_CNT > UNLOCK_CNT) ? LOCK_CNT : UNLOCK_CNT;
  localparam int CW   = $clog2(CMAX + 1);

  localparam logic signed [CORR_W:0] MAXP = {1'b0, MAX_OFFSET};
  localparam logic signed [CORR_W:0] MAXN = -MAXP;

  typedef enum logic {ACQ, TRACK} state_t;

  state_t              state;
  logic [CW-1:0]       cnt;
  logic [CORR_W-1:0]   prev_corr;
  logic                first;

  logic signed [CORR_W:0]   corr_x;
  logic signed [CORR_W:0]   c;
  logic signed [CORR_W-1:0] c_s;
  logic [FTW_W-1:0]         c_f;
  logic                     sat;
  logic [FTW_W-1:0]         tgt;
  logic [FTW_W-1:0]         d;
  logic [FTW_W-1:0]         d_mag;
  logic [FTW_W-1:0]         ftw_nxt;
  logic [CORR_W:0]          cd;
  logic [CORR_W:0]          cd_mag;
  logic                     steady;
  logic [CW-1:0]            cnt_inc;

  // Clamp the correction and form the slew-limited next FTW
  always_comb begin
    corr_x = {i_Carrier_Loop_data[CORR_W-1], i_Carrier_Loop_data};
    if (corr_x > MAXP)
      c = MAXP;
    else if (corr_x < MAXN)
      c = MAXN;
    else
      c = corr_x;
    sat = (c != corr_x);
    c_s = c[CORR_W-1:0];
    tgt = i_ftw_ini + c_f;
    d = tgt - o_ftw;
    d_mag = d[FTW_W-1] ? -d : d;
    if (SLEW_STEP == '0 || d_mag <= SLEW_STEP)
      ftw_nxt = tgt;
    else if (d[FTW_W-1])
      ftw_nxt = o_ftw - SLEW_STEP;
    else
      ftw_nxt = o_ftw + SLEW_STEP;
  end

  if (FTW_W >= CORR_W) begin : g_ext
    assign c_f = FTW_W'(c_s);
  end else begin : g_trunc
    assign c_f = c_s[FTW_W-1:0];
  end

  // Steadiness of the raw correction against the previous sample
  always_comb begin
    cd = {i_Carrier_Loop_data[CORR_W-1], i_Carrier_Loop_data}
       - {prev_corr[CORR_W-1], prev_corr};
    cd_mag = cd[CORR_W] ? -cd : cd;
    steady = !first && (cd_mag <= {1'b0, LOCK_TOL});
    cnt_inc = (cnt == CW'(CMAX)) ? cnt : cnt + 1'b1;
  end

  // FTW register, strobes and lock FSM
  always_ff @(posedge clk) begin
    if (rst || iw_Loop_Filter_ReWork_h) begin
      o_ftw       <= i_ftw_ini;
      o_ftw_valid <= !rst;
      o_locked    <= 1'b0;
      o_sat       <= 1'b0;
      state       <= ACQ;
      cnt         <= '0;
      prev_corr   <= '0;
      first       <= 1'b1;
    end else if (i_hold) begin
      o_ftw_valid <= 1'b0;
    end else if (i_Carrier_Loop_valid) begin
      o_ftw       <= ftw_nxt;
      o_ftw_valid <= 1'b1;
      o_sat       <= sat;
      prev_corr   <= i_Carrier_Loop_data;
      first       <= 1'b0;
      unique case (state)
        ACQ: begin
          if (!steady) begin
            cnt <= '0;
          end else if (cnt_inc >= CW'(LOCK_CNT)) begin
            state    <= TRACK;
            o_locked <= 1'b1;
            cnt      <= '0;
          end else begin
            cnt <= cnt_inc;
          end
        end
        TRACK: begin
          if (steady) begin
            cnt <= '0;
          end else if (cnt_inc >= CW'(UNLOCK_CNT)) begin
            state    <= ACQ;
            o_locked <= 1'b0;
            cnt      <= '0;
          end else begin
            cnt <= cnt_inc;
          end
        end
        default: begin
          state <= ACQ;
          cnt   <= '0;
        end
      endcase
    end else begin
      o_ftw_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_costas_ftw_ctrl.sv
// Bench for costas_ftw_ctrl: vector table, directed slew/lock
// sequences and random stimulus against a behavioural model.
module tb_costas_ftw_ctrl;

  localparam longint MAXO   = 64'h0100_0000;
  localparam longint TOL    = 64'h0000_1000;
  localparam int     LOCKN  = 64;
  localparam int     ULOCKN = 16;

  logic        clk = 1'b0;
  logic        rst, rework, hold, valid;
  logic [31:0] ini, corr;
  logic [31:0] ftw_a, ftw_b;
  logic        fv_a, fv_b, lk_a, lk_b, st_a, st_b;

  always #5 clk = ~clk;

  costas_ftw_ctrl dut_a (
    .clk(clk), .rst(rst),
    .iw_Loop_Filter_ReWork_h(rework),
    .i_hold(hold), .i_ftw_ini(ini),
    .i_Carrier_Loop_data(corr),
    .i_Carrier_Loop_valid(valid),
    .o_ftw(ftw_a), .o_ftw_valid(fv_a),
    .o_locked(lk_a), .o_sat(st_a)
  );

  costas_ftw_ctrl #(.SLEW_STEP(32'h10)) dut_b (
    .clk(clk), .rst(rst),
    .iw_Loop_Filter_ReWork_h(rework),
    .i_hold(hold), .i_ftw_ini(ini),
    .i_Carrier_Loop_data(corr),
    .i_Carrier_Loop_valid(valid),
    .o_ftw(ftw_b), .o_ftw_valid(fv_b),
    .o_locked(lk_b), .o_sat(st_b)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // behavioural reference: index 0 = no slew, 1 = slew 0x10
  logic [31:0] m_ftw[2];
  bit          m_v[2], m_lk[2], m_sat[2], m_first[2];
  int          m_run[2];
  longint      m_prev[2];
  longint      slew_of[2] = '{0, 16};

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      longint cs, c, ds, mag, df;
      logic [31:0] cl, tgt, dd;
      bit steady;
      if (rst || rework) begin
        m_ftw[k] = ini; m_v[k] = !rst; m_lk[k] = 0; m_sat[k] = 0;
        m_run[k] = 0; m_prev[k] = 0; m_first[k] = 1;
      end else if (hold) begin
        m_v[k] = 0;
      end else if (valid) begin
        cs = longint'($signed(corr));
        c = cs;
        if (c > MAXO) c = MAXO;
        if (c < -MAXO) c = -MAXO;
        m_sat[k] = (c != cs);
        cl = c[31:0];
        tgt = ini + cl;
        dd = tgt - m_ftw[k];
        ds = longint'($signed(dd));
        mag = (ds < 0) ? -ds : ds;
        if (slew_of[k] == 0 || mag <= slew_of[k])
          m_ftw[k] = tgt;
        else if (ds < 0)
          m_ftw[k] = m_ftw[k] - 32'(slew_of[k]);
        else
          m_ftw[k] = m_ftw[k] + 32'(slew_of[k]);
        m_v[k] = 1;
        df = cs - m_prev[k];
        if (df < 0) df = -df;
        steady = !m_first[k] && (df <= TOL);
        m_prev[k] = cs;
        m_first[k] = 0;
        if (!m_lk[k]) begin
          m_run[k] = steady ? m_run[k] + 1 : 0;
          if (m_run[k] >= LOCKN) begin m_lk[k] = 1; m_run[k] = 0; end
        end else begin
          m_run[k] = steady ? 0 : m_run[k] + 1;
          if (m_run[k] >= ULOCKN) begin m_lk[k] = 0; m_run[k] = 0; end
        end
      end else begin
        m_v[k] = 0;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    chk("ftw_a", ftw_a, m_ftw[0]);
    chk("fv_a", 32'(fv_a), 32'(m_v[0]));
    chk("lk_a", 32'(lk_a), 32'(m_lk[0]));
    chk("sat_a", 32'(st_a), 32'(m_sat[0]));
    chk("ftw_b", ftw_b, m_ftw[1]);
    chk("fv_b", 32'(fv_b), 32'(m_v[1]));
    chk("lk_b", 32'(lk_b), 32'(m_lk[1]));
    chk("sat_b", 32'(st_b), 32'(m_sat[1]));
  endtask

  task automatic drive(bit r, bit rw, bit h, bit v,
                       logic [31:0] i, logic [31:0] cr);
    rst = r; rework = rw; hold = h; valid = v; ini = i; corr = cr;
  endtask

  typedef struct {
    bit          r, rw, h, v;
    logic [31:0] ini, corr, eftw;
    bit          ev, esat, elk;
  } vec_t;

  vec_t tbl[11];
  logic [31:0] ramp[4];
  logic [31:0] base, b_ini;

  initial begin
    tbl[0]  = '{1,0,0,0, 32'h1000_0000, 32'h0,         32'h1000_0000, 0,0,0};
    tbl[1]  = '{0,0,0,1, 32'h1000_0000, 32'h100,       32'h1000_0100, 1,0,0};
    tbl[2]  = '{0,0,0,0, 32'h1000_0000, 32'h0,         32'h1000_0100, 0,0,0};
    tbl[3]  = '{0,0,0,1, 32'h1000_0000, 32'h7FFF_FFFF, 32'h1100_0000, 1,1,0};
    tbl[4]  = '{0,0,0,1, 32'h1000_0000, 32'h8000_0001, 32'h0F00_0000, 1,1,0};
    tbl[5]  = '{0,0,0,1, 32'hFFFF_FF00, 32'h200,       32'h0000_0100, 1,0,0};
    tbl[6]  = '{0,0,1,1, 32'hFFFF_FF00, 32'h5000,      32'h0000_0100, 0,0,0};
    tbl[7]  = '{0,0,1,0, 32'hFFFF_FF00, 32'h0,         32'h0000_0100, 0,0,0};
    tbl[8]  = '{0,1,0,1, 32'hFFFF_FF00, 32'h300,       32'hFFFF_FF00, 1,0,0};
    tbl[9]  = '{0,0,0,1, 32'h2000_0000, 32'hFFFF_FF00, 32'h1FFF_FF00, 1,0,0};
    tbl[10] = '{1,0,0,0, 32'h2000_0000, 32'h0,         32'h2000_0000, 0,0,0};
    ramp = '{32'h10, 32'h20, 32'h30, 32'h35};

    drive(1, 0, 0, 0, 32'h0, 32'h0);
    #1;
    for (int i = 0; i < 11; i++) begin
      drive(tbl[i].r, tbl[i].rw, tbl[i].h, tbl[i].v, tbl[i].ini, tbl[i].corr);
      step();
      chk($sformatf("tbl%0d_ftw", i), ftw_a, tbl[i].eftw);
      chk($sformatf("tbl%0d_v", i), 32'(fv_a), 32'(tbl[i].ev));
      chk($sformatf("tbl%0d_sat", i), 32'(st_a), 32'(tbl[i].esat));
      chk($sformatf("tbl%0d_lk", i), 32'(lk_a), 32'(tbl[i].elk));
    end

    drive(1, 0, 0, 0, 32'h4000_0000, 32'h0);
    step();
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 1, 32'h4000_0000, 32'h35);
      step();
      chk($sformatf("slew%0d", i), ftw_b, 32'h4000_0000 + ramp[i]);
      chk($sformatf("slew%0d_v", i), 32'(fv_b), 32'd1);
    end
    drive(0, 0, 0, 0, 32'h4000_0000, 32'h0);
    step();
    chk("slew_idle_v", 32'(fv_b), 32'd0);

    drive(1, 0, 0, 0, 32'h3000_0000, 32'h0);
    step();
    for (int i = 1; i <= 65; i++) begin
      drive(0, 0, 0, 1, 32'h3000_0000, 32'h1234);
      step();
      chk($sformatf("lock%0d", i), 32'(lk_a), 32'(i == 65));
    end
    for (int j = 1; j <= 16; j++) begin
      drive(0, 0, 0, 1, 32'h3000_0000,
            (j % 2 == 1) ? 32'h0001_0000 : 32'hFFFF_0000);
      step();
      chk($sformatf("unlock%0d", j), 32'(lk_a), 32'(j < 16));
    end
    for (int i = 1; i <= 65; i++) begin
      drive(0, 0, 0, 1, 32'h3000_0000, 32'h1234);
      step();
    end
    chk("relock", 32'(lk_a), 32'd1);
    drive(0, 0, 1, 1, 32'h3000_0000, 32'h0050_0000);
    step();
    chk("hold_lk", 32'(lk_a), 32'd1);
    chk("hold_v", 32'(fv_a), 32'd0);
    drive(0, 1, 0, 1, 32'h3100_0000, 32'h500);
    step();
    chk("rw_ftw", ftw_a, 32'h3100_0000);
    chk("rw_lk", 32'(lk_a), 32'd0);
    chk("rw_v", 32'(fv_a), 32'd1);

    base = $urandom;
    b_ini = $urandom;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 199) == 0) base = $urandom;
      if ($urandom_range(0, 299) == 0) b_ini = $urandom;
      drive($urandom_range(0, 999) == 0,
            $urandom_range(0, 499) == 0,
            $urandom_range(0, 7) == 0,
            $urandom_range(0, 1) == 1,
            b_ini,
            ($urandom_range(0, 63) == 0) ? 32'($urandom)
              : base + 32'($urandom_range(0, 32'h800)));
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
